controlador_acceso_param: RTL and testbench
===========================================

Name: controlador_acceso_param

Overview:
Parametrised next-generation parking-gate controller. Adds pin width and value parameters, a configurable retry limit, a strobe-qualified pin bus, an open-gate timeout, an admin-only unlock of tailgating lockout, and a lot-occupancy counter with a full flag. It sits between the keypad/vehicle sensors and the gate actuator. All outputs are registered (Moore).

Parameters:
PIN_W, 8, pin bus width in bits
PIN_OK, 8'h08, user pin that opens the gate
PIN_ADMIN, 8'hA5, admin pin; the only pin that clears BLOQUEADA
MAX_INTENTOS, 3, wrong pins accepted before ALERTA (>=1)
T_ABIERTO, 16, cycles ABIERTA may last without Termino before forced close (>=2)
CAPACIDAD, 4, lot capacity in vehicles (>=1)

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
Pin  in  PIN_W  keypad value; sampled only when Pin_valido=1
Pin_valido  in  1  one-cycle strobe qualifying Pin
Vehiculo  in  1  vehicle present at entry
Termino  in  1  vehicle has fully passed the gate
Salida  in  1  one-cycle pulse: a vehicle left the lot by the exit lane
Cerrado  out  1  gate closed
Abierto  out  1  gate open
Alarma  out  1  alarm
Bloqueo  out  1  lockout active
Lleno  out  1  Ocupacion == CAPACIDAD
Ocupacion  out  $clog2(CAPACIDAD+1)  vehicles in lot
Intentos  out  $clog2(MAX_INTENTOS+1)  consecutive wrong pins

Behaviour:
- Reset (async assert, sync release): state=CERRADA, Intentos=0, Ocupacion=0, timer=0. Outputs are Cerrado=1 and all others 0. This applies mid-operation too.
- States are one-hot: CERRADA, ABIERTA, ALERTA, BLOQUEADA.
- Output decode per state:
  - CERRADA: Cerrado=1.
  - ABIERTA: Abierto=1.
  - ALERTA: Cerrado=1, Alarma=1.
  - BLOQUEADA: Alarma=1, Bloqueo=1; Cerrado=0 and Abierto=0.
  - Lleno and Ocupacion are independent of state.
- A pin event is Pin_valido=1 sampled at a rising edge. Pin is ignored otherwise. An all-zero Pin has no special meaning.
- CERRADA, pin event with Vehiculo=1:
  - Pin==PIN_OK and !Lleno -> ABIERTA. Abierto=1 on the next cycle (1-cycle latency). Intentos<=0.
  - Pin==PIN_OK and Lleno -> stay in CERRADA. Not counted as a failure.
  - Pin!=PIN_OK: Intentos<=Intentos+1. If the new value == MAX_INTENTOS -> ALERTA.
- CERRADA, pin event with Vehiculo=0: ignored.
- ALERTA:
  - Pin event with Pin==PIN_OK -> CERRADA, Intentos<=0. No gate open; the driver re-enters the pin.
  - Other pins: Intentos saturates at MAX_INTENTOS.
  - Pin event with Pin==PIN_ADMIN: same effect as PIN_OK.
- ABIERTA:
  - Timer counts from 0 each cycle.
  - Termino=1 and Vehiculo=0 -> CERRADA, Ocupacion increments.
  - Termino=1 and Vehiculo=1 (tailgate) -> BLOQUEADA, Ocupacion increments.
  - Timer reaches T_ABIERTO-1 with no Termino -> CERRADA, no increment.
  - Termino on the same cycle as timeout: Termino wins.
  - Pin events are ignored.
- BLOQUEADA:
  - Only a pin event with Pin==PIN_ADMIN -> CERRADA, Intentos<=0.
  - PIN_OK and all other pins are ignored; Intentos is unchanged.
- Occupancy counter:
  - Salida decrements Ocupacion; it is ignored at 0 (no underflow).
  - An increment at CAPACIDAD cannot occur because !Lleno gates the open. The counter still saturates defensively.
  - Simultaneous increment and Salida: Ocupacion unchanged (if 0, increment only).
  - Salida is honoured in every state.
- Lleno is registered with Ocupacion, so it updates in the same cycle as the count.

Decomposition:
- Package controlador_pkg holds:
  - state typedef/localparams (one-hot, 4 bits);
  - output-decode constants;
  - width helper functions for Ocupacion and Intentos.
- One sub-module, contador_ocupacion: up/down saturating counter with inc, dec, full, count, parametrised by CAPACIDAD.
- The FSM, retry counter and timer stay in the top module.

Test Plan:
- Reset then Vehiculo=1, Pin=8'h08 with Pin_valido -> Abierto=1 next cycle. Then Termino=1, Vehiculo=0 -> Cerrado=1, Ocupacion=1, Intentos=0.
- Three wrong pins (8'h11, 8'h22, 8'h33) with Vehiculo=1 -> Intentos 1, 2, then ALERTA (Alarma=1, Cerrado=1). Then 8'h08 -> CERRADA, Intentos=0, Abierto stays 0.
- Open with 8'h08, then Termino=1 and Vehiculo=1 together -> Bloqueo=1, Alarma=1, Ocupacion=1. 8'h08 -> stays blocked. 8'hA5 -> Cerrado=1, Bloqueo=0.
- Open, then hold Termino=0 for 16 cycles -> Cerrado=1 on cycle 16, Ocupacion unchanged. Repeat with Termino on cycle 15 -> increments.
- Fill to 4 (Lleno=1). Then 8'h08 -> stays CERRADA, Intentos=0. Salida pulse -> Ocupacion=3, Lleno=0. Salida at Ocupacion=0 -> stays 0.
- Drop Reset_n asynchronously while ABIERTA with Ocupacion=2 -> outputs reset immediately (Cerrado=1, Ocupacion=0) without a clock edge.

Source files
------------

// File: rtl/controlador_pkg.sv
// Shared types and helpers for the parking-gate controller: one-hot states, output decode, counter widths.
// Pure definitions; no latency, no flow control.
package controlador_pkg;

    typedef enum logic [3:0] {
        CERRADA   = 4'b0001,
        ABIERTA   = 4'b0010,
        ALERTA    = 4'b0100,
        BLOQUEADA = 4'b1000
    } estado_t;

    // Output vector order: {Bloqueo, Alarma, Abierto, Cerrado}
    localparam logic [3:0] SAL_CERRADA   = 4'b0001;
    localparam logic [3:0] SAL_ABIERTA   = 4'b0010;
    localparam logic [3:0] SAL_ALERTA    = 4'b0101;
    localparam logic [3:0] SAL_BLOQUEADA = 4'b1100;

    function automatic int ancho_ocupacion(input int capacidad);
        return $clog2(capacidad + 1);
    endfunction

    function automatic int ancho_intentos(input int max_intentos);
        return $clog2(max_intentos + 1);
    endfunction

    function automatic logic [3:0] decodificar(input estado_t e);
        logic [3:0] s;
        case (e)
            ABIERTA:   s = SAL_ABIERTA;
            ALERTA:    s = SAL_ALERTA;
            BLOQUEADA: s = SAL_BLOQUEADA;
            default:   s = SAL_CERRADA;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/controlador_acceso_param_contador.sv
// Saturating up/down lot-occupancy counter with a registered full flag.
// Count and full update one cycle after inc/dec; no backpressure, requests are never stalled.
module contador_ocupacion
    import controlador_pkg::*;
#(
    parameter int CAPACIDAD = 4,
    parameter int ANCHO     = ancho_ocupacion(CAPACIDAD)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic             full_o,
    output logic [ANCHO-1:0] count_o
);

    localparam logic [ANCHO-1:0] CAP_V = ANCHO'(CAPACIDAD);
    localparam logic [ANCHO-1:0] UNO   = ANCHO'(1);

    logic [ANCHO-1:0] count_q, count_d;
    logic             full_q;

    // A simultaneous entry and exit cancel, except at zero where only the entry is real.
    always_comb begin
        count_d = count_q;
        if (inc_i && dec_i) begin
            if (count_q == '0) count_d = count_q + UNO;
        end else if (inc_i) begin
            if (count_q != CAP_V) count_d = count_q + UNO;
        end else if (dec_i) begin
            if (count_q != '0) count_d = count_q - UNO;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CAP_V);
        end
    end

    assign count_o = count_q;
    assign full_o  = full_q;

endmodule

// File: rtl/controlador_acceso_param.sv
// Parking-gate controller: pin-qualified opening, retry alert, tailgate lockout, open timeout, occupancy.
// Moore outputs registered, 1-cycle latency from input to output; no backpressure.
module controlador_acceso_param
    import controlador_pkg::*;
#(
    parameter int               PIN_W        = 8,
    parameter logic [PIN_W-1:0] PIN_OK       = PIN_W'(8'h08),
    parameter logic [PIN_W-1:0] PIN_ADMIN    = PIN_W'(8'hA5),
    parameter int               MAX_INTENTOS = 3,
    parameter int               T_ABIERTO    = 16,
    parameter int               CAPACIDAD    = 4
) (
    input  logic                                     Clk,
    input  logic                                     Reset_n,
    input  logic [PIN_W-1:0]                         Pin,
    input  logic                                     Pin_valido,
    input  logic                                     Vehiculo,
    input  logic                                     Termino,
    input  logic                                     Salida,
    output logic                                     Cerrado,
    output logic                                     Abierto,
    output logic                                     Alarma,
    output logic                                     Bloqueo,
    output logic                                     Lleno,
    output logic [ancho_ocupacion(CAPACIDAD)-1:0]    Ocupacion,
    output logic [ancho_intentos(MAX_INTENTOS)-1:0]  Intentos
);

    localparam int             IW    = ancho_intentos(MAX_INTENTOS);
    localparam int             TW    = $clog2(T_ABIERTO);
    localparam logic [IW-1:0]  MAX_V = IW'(MAX_INTENTOS);
    localparam logic [TW-1:0]  T_FIN = TW'(T_ABIERTO - 1);

    estado_t       estado_q, estado_d;
    logic [IW-1:0] intentos_q, intentos_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    salidas_q;
    logic          entra;
    logic          lleno;

    always_comb begin
        estado_d   = estado_q;
        intentos_d = intentos_q;
        timer_d    = '0;
        entra      = 1'b0;
        case (estado_q)
            CERRADA: begin
                if (Pin_valido && Vehiculo) begin
                    if (Pin == PIN_OK) begin
                        if (!lleno) begin
                            estado_d   = ABIERTA;
                            intentos_d = '0;
                        end
                    end else begin
                        intentos_d = intentos_q + IW'(1);
                        if (intentos_d == MAX_V) estado_d = ALERTA;
                    end
                end
            end
            ABIERTA: begin
                // Termino takes priority over a timeout on the same cycle.
                if (Termino) begin
                    entra    = 1'b1;
                    estado_d = Vehiculo ? BLOQUEADA : CERRADA;
                end else if (timer_q == T_FIN) begin
                    estado_d = CERRADA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ALERTA: begin
                if (Pin_valido) begin
                    if (Pin == PIN_OK || Pin == PIN_ADMIN) begin
                        estado_d   = CERRADA;
                        intentos_d = '0;
                    end else if (intentos_q != MAX_V) begin
                        intentos_d = intentos_q + IW'(1);
                    end
                end
            end
            BLOQUEADA: begin
                if (Pin_valido && Pin == PIN_ADMIN) begin
                    estado_d   = CERRADA;
                    intentos_d = '0;
                end
            end
            default: estado_d = CERRADA;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q   <= CERRADA;
            intentos_q <= '0;
            timer_q    <= '0;
            salidas_q  <= SAL_CERRADA;
        end else begin
            estado_q   <= estado_d;
            intentos_q <= intentos_d;
            timer_q    <= timer_d;
            salidas_q  <= decodificar(estado_d);
        end
    end

    contador_ocupacion #(
        .CAPACIDAD (CAPACIDAD),
        .ANCHO     (ancho_ocupacion(CAPACIDAD))
    ) u_contador (
        .clk_i   (Clk),
        .rst_n_i (Reset_n),
        .inc_i   (entra),
        .dec_i   (Salida),
        .full_o  (lleno),
        .count_o (Ocupacion)
    );

    assign Cerrado  = salidas_q[0];
    assign Abierto  = salidas_q[1];
    assign Alarma   = salidas_q[2];
    assign Bloqueo  = salidas_q[3];
    assign Lleno    = lleno;
    assign Intentos = intentos_q;

endmodule

// File: tb/tb_controlador_acceso_param.sv
// Scoreboard bench for controlador_acceso_param: directed vectors push expected outputs, a negedge monitor compares.
module tb_controlador_acceso_param;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] Pin = 8'h00;
    logic       Pin_valido = 1'b0;
    logic       Vehiculo = 1'b0;
    logic       Termino = 1'b0;
    logic       Salida = 1'b0;
    logic       Cerrado, Abierto, Alarma, Bloqueo, Lleno;
    logic [2:0] Ocupacion;
    logic [1:0] Intentos;

    // Expected output order: {Bloqueo, Alarma, Abierto, Cerrado}
    localparam logic [3:0] E_CER = 4'b0001;
    localparam logic [3:0] E_ABI = 4'b0010;
    localparam logic [3:0] E_ALE = 4'b0101;
    localparam logic [3:0] E_BLO = 4'b1100;

    typedef struct {
        string      nombre;
        logic [3:0] sal;
        logic       lleno;
        logic [2:0] ocup;
        logic [1:0] intentos;
    } esperado_t;

    esperado_t cola[$];
    esperado_t obs;
    int pruebas = 0;
    int fallos  = 0;

    controlador_acceso_param dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Pin        (Pin),
        .Pin_valido (Pin_valido),
        .Vehiculo   (Vehiculo),
        .Termino    (Termino),
        .Salida     (Salida),
        .Cerrado    (Cerrado),
        .Abierto    (Abierto),
        .Alarma     (Alarma),
        .Bloqueo    (Bloqueo),
        .Lleno      (Lleno),
        .Ocupacion  (Ocupacion),
        .Intentos   (Intentos)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (cola.size() > 0) begin
            obs = cola.pop_front();
            pruebas++;
            if ({Bloqueo, Alarma, Abierto, Cerrado} !== obs.sal || Lleno !== obs.lleno ||
                Ocupacion !== obs.ocup || Intentos !== obs.intentos) begin
                fallos++;
                $display("FAIL %s: got {Bloq,Alar,Abi,Cer}=%b Lleno=%b Ocup=%0d Int=%0d, expected %b Lleno=%b Ocup=%0d Int=%0d",
                         obs.nombre, {Bloqueo, Alarma, Abierto, Cerrado}, Lleno, Ocupacion, Intentos,
                         obs.sal, obs.lleno, obs.ocup, obs.intentos);
            end
        end
    end

    task automatic esperar(input string n, input logic [3:0] s, input logic ll, input int oc, input int it);
        esperado_t e;
        e.nombre   = n;
        e.sal      = s;
        e.lleno    = ll;
        e.ocup     = 3'(oc);
        e.intentos = 2'(it);
        cola.push_back(e);
    endtask

    task automatic ciclo();
        @(posedge Clk);
        #1;
    endtask

    task automatic ciclo_chk(input string n, input logic [3:0] s, input logic ll, input int oc, input int it);
        ciclo();
        esperar(n, s, ll, oc, it);
    endtask

    task automatic pin_chk(input logic [7:0] v, input logic veh, input string n,
                           input logic [3:0] s, input logic ll, input int oc, input int it);
        Pin        = v;
        Pin_valido = 1'b1;
        Vehiculo   = veh;
        ciclo_chk(n, s, ll, oc, it);
        Pin_valido = 1'b0;
    endtask

    task automatic termina(input logic veh, input string n, input logic [3:0] s, input logic ll, input int oc);
        Termino  = 1'b1;
        Vehiculo = veh;
        ciclo_chk(n, s, ll, oc, 0);
        Termino  = 1'b0;
        Vehiculo = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        ciclo_chk("reset", E_CER, 1'b0, 0, 0);
        Reset_n = 1'b1;
        ciclo();

        // Basic open and pass
        pin_chk(8'h08, 1'b1, "abre", E_ABI, 1'b0, 0, 0);
        termina(1'b0, "cierra_paso", E_CER, 1'b0, 1);

        // Wrong pins, alert, saturation, recovery
        pin_chk(8'h11, 1'b1, "fallo1", E_CER, 1'b0, 1, 1);
        pin_chk(8'h22, 1'b1, "fallo2", E_CER, 1'b0, 1, 2);
        pin_chk(8'h33, 1'b1, "alerta", E_ALE, 1'b0, 1, 3);
        pin_chk(8'h44, 1'b1, "alerta_sat", E_ALE, 1'b0, 1, 3);
        pin_chk(8'h08, 1'b1, "alerta_ok", E_CER, 1'b0, 1, 0);
        Vehiculo = 1'b0;
        ciclo_chk("sin_abrir", E_CER, 1'b0, 1, 0);

        // Tailgate lockout, only admin clears
        pin_chk(8'h08, 1'b1, "abre2", E_ABI, 1'b0, 1, 0);
        termina(1'b1, "tailgate", E_BLO, 1'b0, 2);
        pin_chk(8'h08, 1'b1, "bloq_ignora_ok", E_BLO, 1'b0, 2, 0);
        pin_chk(8'hA5, 1'b0, "admin", E_CER, 1'b0, 2, 0);

        // Open timeout boundary
        pin_chk(8'h08, 1'b1, "abre3", E_ABI, 1'b0, 2, 0);
        Vehiculo = 1'b0;
        for (int i = 0; i < 14; i++) ciclo();
        ciclo_chk("abierta_ciclo15", E_ABI, 1'b0, 2, 0);
        ciclo_chk("timeout", E_CER, 1'b0, 2, 0);
        pin_chk(8'h08, 1'b1, "abre4", E_ABI, 1'b0, 2, 0);
        Vehiculo = 1'b0;
        for (int i = 0; i < 14; i++) ciclo();
        ciclo_chk("abierta_ciclo15b", E_ABI, 1'b0, 2, 0);
        termina(1'b0, "termino_en_limite", E_CER, 1'b0, 3);

        // Full lot, exits, underflow
        pin_chk(8'h08, 1'b1, "abre5", E_ABI, 1'b0, 3, 0);
        termina(1'b0, "lleno", E_CER, 1'b1, 4);
        pin_chk(8'h08, 1'b1, "lleno_rechazo", E_CER, 1'b1, 4, 0);
        Vehiculo = 1'b0;
        Salida = 1'b1;
        ciclo_chk("salida", E_CER, 1'b0, 3, 0);
        Salida = 1'b0;
        pin_chk(8'h08, 1'b1, "abre6", E_ABI, 1'b0, 3, 0);
        Salida = 1'b1;
        termina(1'b0, "inc_y_dec", E_CER, 1'b0, 3);
        ciclo();
        ciclo();
        ciclo_chk("vacio", E_CER, 1'b0, 0, 0);
        ciclo_chk("sin_underflow", E_CER, 1'b0, 0, 0);
        Salida = 1'b0;
        pin_chk(8'h11, 1'b0, "sin_vehiculo", E_CER, 1'b0, 0, 0);

        // Asynchronous reset while open
        pin_chk(8'h08, 1'b1, "relleno1", E_ABI, 1'b0, 0, 0);
        termina(1'b0, "relleno1_fin", E_CER, 1'b0, 1);
        pin_chk(8'h08, 1'b1, "relleno2", E_ABI, 1'b0, 1, 0);
        termina(1'b0, "relleno2_fin", E_CER, 1'b0, 2);
        pin_chk(8'h08, 1'b1, "abre_pre_reset", E_ABI, 1'b0, 2, 0);
        Vehiculo = 1'b0;
        ciclo();
        Reset_n = 1'b0;
        esperar("reset_async", E_CER, 1'b0, 0, 0);
        ciclo_chk("reset_mantenido", E_CER, 1'b0, 0, 0);
        Reset_n = 1'b1;
        ciclo_chk("tras_reset", E_CER, 1'b0, 0, 0);

        for (int i = 0; i < 10 && cola.size() > 0; i++) begin
            @(negedge Clk);
            #1;
        end
        if (cola.size() > 0) begin
            pruebas++;
            fallos++;
            $display("FAIL drenaje: %0d expectations left unchecked, required 0", cola.size());
        end
        $display("[TB] %0d tests run, %0d failed", pruebas, fallos);
        $finish;
    end

endmodule
